// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths, reset address, AXI-Lite constants and fetch state encodings
// for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  localparam logic [INST_DATA_BUS-1:0] ZEROWORD     = '0;
  localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEF = 32'hBFC0_0000;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_PROT_INST = 3'b100;

  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_HALT = 2'd2;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding AXI-Lite read, a one-entry
// IF/ID output buffer, and redirect handling that discards stale responses.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int                 ADDR_W   = INST_ADDR_BUS,
  parameter int                 DATA_W   = INST_DATA_BUS,
  parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_err
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              drop_q, drop_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic              if_err_q, if_err_d;

  logic              r_hs;
  logic              discard;
  logic              load;
  logic              resp_err;
  logic [ADDR_W-1:0] base;

  // Gate AR valid with reset so nothing is requested while the core is held.
  assign m_arvalid = rst && (state_q == FETCH_REQ);
  assign m_araddr  = fetch_addr_q;
  assign m_arprot  = AXI_PROT_INST;
  // Accept R when the buffer is empty, draining this cycle, or data is dropped.
  assign m_rready  = (state_q == FETCH_WAIT) && (drop_q || !if_valid_q || !id_stall);

  assign r_hs     = m_rvalid && m_rready;
  assign discard  = drop_q || redirect_valid;
  assign load     = r_hs && !discard;
  assign resp_err = (m_rresp != AXI_RESP_OKAY);
  assign base     = redirect_valid ? redirect_pc : pc_q;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_err   = if_err_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;
    case (state_q)
      FETCH_REQ: begin
        // The pending AR keeps its old address; its response is discarded later.
        if (redirect_valid) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
        if (m_arready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (r_hs) begin
          if (discard) drop_d = 1'b0;
          fetch_addr_d = base;
          pc_d         = base + ADDR_W'(4);
          state_d      = (load && resp_err) ? FETCH_HALT : FETCH_REQ;
        end else if (redirect_valid) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end
      FETCH_HALT: begin
        if (redirect_valid) begin
          fetch_addr_d = redirect_pc;
          pc_d         = redirect_pc + ADDR_W'(4);
          state_d      = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH_REQ;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC + ADDR_W'(4);
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_err_d   = if_err_q;
    if (if_valid_q && !id_stall) if_valid_d = 1'b0;
    if (load) begin
      if_valid_d = 1'b1;
      if_pc_d    = fetch_addr_q;
      if_inst_d  = m_rdata;
      if_err_d   = resp_err;
    end
    // A redirect flushes the buffer and wins over any load.
    if (redirect_valid) if_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_err_q   <= 1'b0;
    end else begin
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_err_q   <= if_err_d;
    end
  end

endmodule
